register_file_param: RTL and testbench

Parametrised successor to the CPU's 16x16 general-purpose register file. Provides two combinational read ports and a dedicated r0 read port. Writes go through a general write port and a dedicated r0 write port, which can fire in the same cycle. Adds optional write-to-read bypass and a per-register busy scoreboard so the decode stage can stall on outstanding multi-cycle results.

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/regfile_scoreboard.sv | 54 +++++
 rtl/register_file_param.sv | 111 +++++++++++
 tb/tb_register_file_param.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file definitions: write-mode encodings and default sizing
// used by decode, ALU and the register file itself.
package regfile_pkg;

  localparam logic [1:0] WR_NONE = 2'b00;
  localparam logic [1:0] WR_GEN  = 2'b01;
  localparam logic [1:0] WR_R0   = 2'b10;
  localparam logic [1:0] WR_BOTH = 2'b11;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 16;

  function automatic logic mode_gen(input logic [1:0] m);
    return (m == WR_GEN) || (m == WR_BOTH);
  endfunction

  function automatic logic mode_r0(input logic [1:0] m);
    return (m == WR_R0) || (m == WR_BOTH);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for outstanding multi-cycle results.
// A reserve beats a same-cycle write to the same register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter bit BYPASS   = 1'b1,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en_i,
  input  logic [ADDR_W-1:0]   set_addr_i,
  input  logic [NUM_REGS-1:0] clr_i,
  input  logic [ADDR_W-1:0]   rd1_addr_i,
  input  logic                rd1_ok_i,
  input  logic [ADDR_W-1:0]   rd2_addr_i,
  input  logic                rd2_ok_i,
  output logic                busy1_o,
  output logic                busy2_o
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] set_vec;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      set_vec[i] = set_en_i && (set_addr_i == ADDR_W'(i));
    end
    busy_d = set_vec | (busy_q & ~clr_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A register being written right now is already resolved when bypassing.
  always_comb begin
    busy1_o = 1'b0;
    busy2_o = 1'b0;
    if (rd1_ok_i) begin
      busy1_o = busy_q[rd1_addr_i] & ~(BYPASS & clr_i[rd1_addr_i]);
    end
    if (rd2_ok_i) begin
      busy2_o = busy_q[rd2_addr_i] & ~(BYPASS & clr_i[rd2_addr_i]);
    end
  end

endmodule

// File: rtl/register_file_param.sv
// Parametrised GPR file: two read ports, r0 port, general + r0 write,
// optional same-cycle bypass and a busy scoreboard for decode stalls.
module register_file_param
  import regfile_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                NUM_REGS  = DEF_NUM_REGS,
  parameter bit                BYPASS    = 1'b1,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        registerWrite,
  input  logic [ADDR_W-1:0] regWriteLocal,
  input  logic [DATA_W-1:0] dataWrite,
  input  logic [DATA_W-1:0] r0Write,
  input  logic [ADDR_W-1:0] registerRead1,
  input  logic [ADDR_W-1:0] registerRead2,
  input  logic              reserveEn,
  input  logic [ADDR_W-1:0] reserveReg,
  output logic [DATA_W-1:0] dataRead1,
  output logic [DATA_W-1:0] dataRead2,
  output logic [DATA_W-1:0] r0Read,
  output logic              busy1,
  output logic              busy2
);

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] wr_vec;
  logic                wr_any;
  logic                gen_we;
  logic                r0_we;
  logic                rng1;
  logic                rng2;

  // Writes are squashed during reset so bypass never leaks them out.
  assign wr_any = (registerWrite != WR_NONE) && !reset;
  assign gen_we = wr_any && mode_gen(registerWrite);
  assign r0_we  = wr_any && mode_r0(registerWrite);

  generate
    if (NUM_REGS == (1 << ADDR_W)) begin : g_pow2
      assign rng1 = 1'b1;
      assign rng2 = 1'b1;
    end else begin : g_npow2
      assign rng1 = registerRead1 < ADDR_W'(NUM_REGS);
      assign rng2 = registerRead2 < ADDR_W'(NUM_REGS);
    end
  endgenerate

  // r0 port is applied last so it wins a general write to address 0.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_vec[i] = 1'b0;
      regs_d[i] = regs_q[i];
      if (gen_we && (regWriteLocal == ADDR_W'(i))) begin
        wr_vec[i] = 1'b1;
        regs_d[i] = dataWrite;
      end
      if (r0_we && (i == 0)) begin
        wr_vec[i] = 1'b1;
        regs_d[i] = r0Write;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  always_comb begin
    dataRead1 = '0;
    dataRead2 = '0;
    if (rng1) begin
      dataRead1 = BYPASS ? regs_d[registerRead1] : regs_q[registerRead1];
    end
    if (rng2) begin
      dataRead2 = BYPASS ? regs_d[registerRead2] : regs_q[registerRead2];
    end
    r0Read = BYPASS ? regs_d[0] : regs_q[0];
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .BYPASS   (BYPASS),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .clk        (clk),
    .reset      (reset),
    .set_en_i   (reserveEn),
    .set_addr_i (reserveReg),
    .clr_i      (wr_vec),
    .rd1_addr_i (registerRead1),
    .rd1_ok_i   (rng1),
    .rd2_addr_i (registerRead2),
    .rd2_ok_i   (rng2),
    .busy1_o    (busy1),
    .busy2_o    (busy2)
  );

endmodule

// File: tb/tb_register_file_param.sv
// Scoreboard bench: bypass, non-bypass and a 32x12 instance with
// a non-zero reset value, checked against a small register model.
module tb_register_file_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  mode;
  logic [3:0]  waddr, ra1, ra2, rreg;
  logic [15:0] wdata, r0w;
  logic        ren;

  logic [15:0] b_rd1, b_rd2, b_r0, n_rd1, n_rd2, n_r0;
  logic        b_bs1, b_bs2, n_bs1, n_bs2;

  logic [1:0]  pmode;
  logic [3:0]  pwaddr, pra1, pra2, prreg;
  logic [31:0] pwdata, pr0w;
  logic        pren;
  logic [31:0] p_rd1, p_rd2, p_r0;
  logic        p_bs1, p_bs2;

  localparam logic [31:0] RV = 32'h0000_00C3;

  int total = 0;
  int bad = 0;
  logic [127:0] exp_q[$];
  logic [127:0] ex;
  logic [15:0]  mdl[16];
  logic [15:0]  bsy;

  register_file_param #(
    .DATA_W(16), .NUM_REGS(16), .BYPASS(1'b1), .RESET_VAL(16'h0)
  ) dut_b (
    .clk(clk), .reset(reset), .registerWrite(mode),
    .regWriteLocal(waddr), .dataWrite(wdata), .r0Write(r0w),
    .registerRead1(ra1), .registerRead2(ra2),
    .reserveEn(ren), .reserveReg(rreg),
    .dataRead1(b_rd1), .dataRead2(b_rd2), .r0Read(b_r0),
    .busy1(b_bs1), .busy2(b_bs2)
  );

  register_file_param #(
    .DATA_W(16), .NUM_REGS(16), .BYPASS(1'b0), .RESET_VAL(16'h0)
  ) dut_n (
    .clk(clk), .reset(reset), .registerWrite(mode),
    .regWriteLocal(waddr), .dataWrite(wdata), .r0Write(r0w),
    .registerRead1(ra1), .registerRead2(ra2),
    .reserveEn(ren), .reserveReg(rreg),
    .dataRead1(n_rd1), .dataRead2(n_rd2), .r0Read(n_r0),
    .busy1(n_bs1), .busy2(n_bs2)
  );

  register_file_param #(
    .DATA_W(32), .NUM_REGS(12), .BYPASS(1'b1), .RESET_VAL(RV)
  ) dut_p (
    .clk(clk), .reset(reset), .registerWrite(pmode),
    .regWriteLocal(pwaddr), .dataWrite(pwdata), .r0Write(pr0w),
    .registerRead1(pra1), .registerRead2(pra2),
    .reserveEn(pren), .reserveReg(prreg),
    .dataRead1(p_rd1), .dataRead2(p_rd2), .r0Read(p_r0),
    .busy1(p_bs1), .busy2(p_bs2)
  );

  function automatic logic [127:0] pk(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c, input logic x,
                                      input logic y);
    return {30'b0, a, b, c, x, y};
  endfunction

  function automatic logic [127:0] obs_b();
    return pk(32'(b_rd1), 32'(b_rd2), 32'(b_r0), b_bs1, b_bs2);
  endfunction

  function automatic logic [127:0] obs_n();
    return pk(32'(n_rd1), 32'(n_rd2), 32'(n_r0), n_bs1, n_bs2);
  endfunction

  function automatic logic [127:0] obs_p();
    return pk(p_rd1, p_rd2, p_r0, p_bs1, p_bs2);
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    mode = 2'b00; waddr = 4'd0; wdata = '0; r0w = '0;
    ra1 = 4'd3; ra2 = 4'd5; ren = 1'b0; rreg = 4'd0;
    pmode = 2'b00; pwaddr = 4'd0; pwdata = '0; pr0w = '0;
    pra1 = 4'd13; pra2 = 4'd3; pren = 1'b0; prreg = 4'd0;
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0;
    bsy = '0;
    #1 reset = 1'b1;
    exp_q.push_back(pk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(pk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(pk(32'h0, RV, RV, 1'b0, 1'b0));
    #2;
    ex = exp_q.pop_front(); total++;
    if (obs_b() !== ex) begin bad++; $display("FAIL rst_b got=%h want=%h", obs_b(), ex); end
    ex = exp_q.pop_front(); total++;
    if (obs_n() !== ex) begin bad++; $display("FAIL rst_n got=%h want=%h", obs_n(), ex); end
    ex = exp_q.pop_front(); total++;
    if (obs_p() !== ex) begin bad++; $display("FAIL rst_p got=%h want=%h", obs_p(), ex); end
    #7 reset = 1'b0;
    exp_q.push_back(pk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(pk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_b() !== ex) begin bad++; $display("FAIL idle_b got=%h want=%h", obs_b(), ex); end
    ex = exp_q.pop_front(); total++;
    if (obs_n() !== ex) begin bad++; $display("FAIL idle_n got=%h want=%h", obs_n(), ex); end
  endtask

  task automatic test_gen_write();
    @(negedge clk);
    mode = 2'b01; waddr = 4'd3; wdata = 16'h4020; ra1 = 4'd3; ra2 = 4'd0;
    exp_q.push_back(pk(32'h4020, 32'h0, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(pk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_b() !== ex) begin bad++; $display("FAIL gen_byp got=%h want=%h", obs_b(), ex); end
    ex = exp_q.pop_front(); total++;
    if (obs_n() !== ex) begin bad++; $display("FAIL gen_pre got=%h want=%h", obs_n(), ex); end
    mdl[3] = 16'h4020;
    exp_q.push_back(pk(32'h4020, 32'h0, 32'h0, 1'b0, 1'b0));
    @(posedge clk); #1;
    ex = exp_q.pop_front(); total++;
    if (obs_n() !== ex) begin bad++; $display("FAIL gen_post got=%h want=%h", obs_n(), ex); end
    @(negedge clk) mode = 2'b00;
  endtask

  task automatic test_r0_dual();
    @(negedge clk);
    mode = 2'b10; r0w = 16'h1239; ra1 = 4'd3; ra2 = 4'd0;
    exp_q.push_back(pk(32'h4020, 32'h1239, 32'h1239, 1'b0, 1'b0));
    exp_q.push_back(pk(32'h4020, 32'h0, 32'h0, 1'b0, 1'b0));
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_b() !== ex) begin bad++; $display("FAIL r0_byp got=%h want=%h", obs_b(), ex); end
    ex = exp_q.pop_front(); total++;
    if (obs_n() !== ex) begin bad++; $display("FAIL r0_pre got=%h want=%h", obs_n(), ex); end
    exp_q.push_back(pk(32'h4020, 32'h1239, 32'h1239, 1'b0, 1'b0));
    @(posedge clk); #1;
    ex = exp_q.pop_front(); total++;
    if (obs_n() !== ex) begin bad++; $display("FAIL r0_post got=%h want=%h", obs_n(), ex); end

    @(negedge clk);
    mode = 2'b11; waddr = 4'd5; wdata = 16'h00AA; r0w = 16'h1111;
    ra1 = 4'd5; ra2 = 4'd0;
    mdl[5] = 16'h00AA;
    exp_q.push_back(pk(32'h00AA, 32'h1111, 32'h1111, 1'b0, 1'b0));
    exp_q.push_back(pk(32'h00AA, 32'h1111, 32'h1111, 1'b0, 1'b0));
    @(negedge clk) mode = 2'b00;
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_b() !== ex) begin bad++; $display("FAIL dual_b got=%h want=%h", obs_b(), ex); end
    ex = exp_q.pop_front(); total++;
    if (obs_n() !== ex) begin bad++; $display("FAIL dual_n got=%h want=%h", obs_n(), ex); end

    @(negedge clk);
    mode = 2'b11; waddr = 4'd0; wdata = 16'hBEEF; r0w = 16'h1234;
    ra1 = 4'd0; ra2 = 4'd0;
    exp_q.push_back(pk(32'h1234, 32'h1234, 32'h1234, 1'b0, 1'b0));
    exp_q.push_back(pk(32'h1111, 32'h1111, 32'h1111, 1'b0, 1'b0));
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_b() !== ex) begin bad++; $display("FAIL conf_byp got=%h want=%h", obs_b(), ex); end
    ex = exp_q.pop_front(); total++;
    if (obs_n() !== ex) begin bad++; $display("FAIL conf_pre got=%h want=%h", obs_n(), ex); end
    mdl[0] = 16'h1234;
    exp_q.push_back(pk(32'h1234, 32'h1234, 32'h1234, 1'b0, 1'b0));
    exp_q.push_back(pk(32'h1234, 32'h1234, 32'h1234, 1'b0, 1'b0));
    @(negedge clk) mode = 2'b00;
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_b() !== ex) begin bad++; $display("FAIL conf_b got=%h want=%h", obs_b(), ex); end
    ex = exp_q.pop_front(); total++;
    if (obs_n() !== ex) begin bad++; $display("FAIL conf_n got=%h want=%h", obs_n(), ex); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    mode = 2'b00; ren = 1'b1; rreg = 4'd7; ra1 = 4'd7; ra2 = 4'd7;
    exp_q.push_back(pk(32'h0, 32'h0, 32'h1234, 1'b0, 1'b0));
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_b() !== ex) begin bad++; $display("FAIL rsv_pre got=%h want=%h", obs_b(), ex); end
    bsy[7] = 1'b1;
    exp_q.push_back(pk(32'h0, 32'h0, 32'h1234, 1'b1, 1'b1));
    exp_q.push_back(pk(32'h0, 32'h0, 32'h1234, 1'b1, 1'b1));
    @(negedge clk) ren = 1'b0;
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_b() !== ex) begin bad++; $display("FAIL rsv_b got=%h want=%h", obs_b(), ex); end
    ex = exp_q.pop_front(); total++;
    if (obs_n() !== ex) begin bad++; $display("FAIL rsv_n got=%h want=%h", obs_n(), ex); end

    @(negedge clk);
    mode = 2'b01; waddr = 4'd7; wdata = 16'h0042;
    exp_q.push_back(pk(32'h0042, 32'h0042, 32'h1234, 1'b0, 1'b0));
    exp_q.push_back(pk(32'h0, 32'h0, 32'h1234, 1'b1, 1'b1));
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_b() !== ex) begin bad++; $display("FAIL clr_byp got=%h want=%h", obs_b(), ex); end
    ex = exp_q.pop_front(); total++;
    if (obs_n() !== ex) begin bad++; $display("FAIL clr_pre got=%h want=%h", obs_n(), ex); end
    mdl[7] = 16'h0042; bsy[7] = 1'b0;
    exp_q.push_back(pk(32'h0042, 32'h0042, 32'h1234, 1'b0, 1'b0));
    @(negedge clk) mode = 2'b00;
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_n() !== ex) begin bad++; $display("FAIL clr_n got=%h want=%h", obs_n(), ex); end

    @(negedge clk);
    mode = 2'b01; waddr = 4'd7; wdata = 16'h0055; ren = 1'b1; rreg = 4'd7;
    mdl[7] = 16'h0055; bsy[7] = 1'b1;
    exp_q.push_back(pk(32'h0055, 32'h0055, 32'h1234, 1'b1, 1'b1));
    exp_q.push_back(pk(32'h0055, 32'h0055, 32'h1234, 1'b1, 1'b1));
    @(negedge clk);
    mode = 2'b00; ren = 1'b0;
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_b() !== ex) begin bad++; $display("FAIL rsv_win_b got=%h want=%h", obs_b(), ex); end
    ex = exp_q.pop_front(); total++;
    if (obs_n() !== ex) begin bad++; $display("FAIL rsv_win_n got=%h want=%h", obs_n(), ex); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    logic [3:0]  a;
    for (int k = 0; k < 6; k++) begin
      a = 4'(8 + k);
      d = 16'($urandom);
      @(negedge clk);
      mode = 2'b01; waddr = a; wdata = d; ra1 = a; ra2 = a - 4'd1;
      exp_q.push_back(pk(32'(d), 32'(mdl[a-4'd1]), 32'h1234, 1'b0, bsy[a-4'd1]));
      exp_q.push_back(pk(32'(mdl[a]), 32'(mdl[a-4'd1]), 32'h1234, bsy[a], bsy[a-4'd1]));
      #1;
      ex = exp_q.pop_front(); total++;
      if (obs_b() !== ex) begin bad++; $display("FAIL b2b_b k=%0d got=%h want=%h", k, obs_b(), ex); end
      ex = exp_q.pop_front(); total++;
      if (obs_n() !== ex) begin bad++; $display("FAIL b2b_n k=%0d got=%h want=%h", k, obs_n(), ex); end
      mdl[a] = d; bsy[a] = 1'b0;
    end
    @(negedge clk) mode = 2'b00;
    for (int i = 0; i < 16; i++) begin
      ra1 = 4'(i); ra2 = 4'(15 - i);
      exp_q.push_back(pk(32'(mdl[i]), 32'(mdl[15-i]), 32'h1234, bsy[i], bsy[15-i]));
      exp_q.push_back(pk(32'(mdl[i]), 32'(mdl[15-i]), 32'h1234, bsy[i], bsy[15-i]));
      #1;
      ex = exp_q.pop_front(); total++;
      if (obs_b() !== ex) begin bad++; $display("FAIL dump_b r%0d got=%h want=%h", i, obs_b(), ex); end
      ex = exp_q.pop_front(); total++;
      if (obs_n() !== ex) begin bad++; $display("FAIL dump_n r%0d got=%h want=%h", i, obs_n(), ex); end
    end
  endtask

  task automatic test_param();
    @(negedge clk);
    pmode = 2'b01; pwaddr = 4'd13; pwdata = 32'hFFFF_FFFF;
    pra1 = 4'd13; pra2 = 4'd11; pren = 1'b1; prreg = 4'd13;
    exp_q.push_back(pk(32'h0, RV, RV, 1'b0, 1'b0));
    exp_q.push_back(pk(32'h0, RV, RV, 1'b0, 1'b0));
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_p() !== ex) begin bad++; $display("FAIL oob_byp got=%h want=%h", obs_p(), ex); end
    @(negedge clk);
    pmode = 2'b00; pren = 1'b0;
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_p() !== ex) begin bad++; $display("FAIL oob_post got=%h want=%h", obs_p(), ex); end
    for (int i = 0; i < 12; i++) begin
      pra1 = 4'(i);
      exp_q.push_back(pk(RV, RV, RV, 1'b0, 1'b0));
      #1;
      ex = exp_q.pop_front(); total++;
      if (obs_p() !== ex) begin bad++; $display("FAIL oob_r%0d got=%h want=%h", i, obs_p(), ex); end
    end

    @(negedge clk);
    pmode = 2'b01; pwaddr = 4'd11; pwdata = 32'hDEAD_BEEF;
    pra1 = 4'd13; pra2 = 4'd11;
    exp_q.push_back(pk(32'h0, 32'hDEAD_BEEF, RV, 1'b0, 1'b0));
    @(negedge clk) pmode = 2'b00;
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_p() !== ex) begin bad++; $display("FAIL r11_wr got=%h want=%h", obs_p(), ex); end

    @(negedge clk);
    ra1 = 4'd3; ra2 = 4'd7;
    pmode = 2'b01; pwaddr = 4'd11; pwdata = 32'h1234_5678;
    pren = 1'b1; prreg = 4'd11;
    reset = 1'b1;
    exp_q.push_back(pk(32'h0, RV, RV, 1'b0, 1'b0));
    exp_q.push_back(pk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0));
    exp_q.push_back(pk(32'h0, RV, RV, 1'b0, 1'b0));
    exp_q.push_back(pk(32'h0, RV, RV, 1'b0, 1'b0));
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_p() !== ex) begin bad++; $display("FAIL mid_rst got=%h want=%h", obs_p(), ex); end
    ex = exp_q.pop_front(); total++;
    if (obs_b() !== ex) begin bad++; $display("FAIL mid_rst_b got=%h want=%h", obs_b(), ex); end
    @(posedge clk); #1;
    ex = exp_q.pop_front(); total++;
    if (obs_p() !== ex) begin bad++; $display("FAIL rst_edge got=%h want=%h", obs_p(), ex); end
    @(negedge clk);
    reset = 1'b0; pmode = 2'b00; pren = 1'b0;
    #1;
    ex = exp_q.pop_front(); total++;
    if (obs_p() !== ex) begin bad++; $display("FAIL rst_rel got=%h want=%h", obs_p(), ex); end
  endtask

  initial begin
    test_reset();
    test_gen_write();
    test_r0_dual();
    test_scoreboard();
    test_back_to_back();
    test_param();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_left got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
